// File: rtl/mul_approx_pipe.sv
// Pipelined unsigned approximate multiplier with per-item truncation depth and optional
// error compensation. Partial-product rows are reduced in STAGES slices behind an elastic pipeline.
module mul_approx_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 2,
  localparam int TW     = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TW-1:0]      trunc,
  input  logic               comp_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o
);

  localparam int PW  = 2 * WIDTH;
  localparam int RPG = (WIDTH + STAGES - 1) / STAGES;

  // Sum of rows lo..hi-1 of the partial-product array, with every column below tv dropped.
  function automatic logic [PW-1:0] rows_sum(input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv,
                                             input logic [TW-1:0]    tv,
                                             input int               lo,
                                             input int               hi);
    logic [PW-1:0] mask;
    logic [PW-1:0] sum;
    mask = '0;
    sum  = '0;
    for (int p = 0; p < PW; p++) begin
      mask[p] = (p >= int'(tv));
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (j >= lo && j < hi && bv[j]) begin
        sum = sum + ((PW'(av) << j) & mask);
      end
    end
    return sum;
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [PW-1:0]     acc_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [TW-1:0]     t_q   [STAGES];

  logic [STAGES-1:0] slot_load;
  logic [STAGES-1:0] src_valid;
  logic [PW-1:0]     src_acc [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [TW-1:0]     src_t   [STAGES];
  logic [PW-1:0]     grp_sum [STAGES];
  logic [PW-1:0]     acc_d   [STAGES];

  logic [TW-1:0]     t_in;
  logic [PW-1:0]     comp_in;

  assign t_in    = (trunc > TW'(WIDTH)) ? TW'(WIDTH) : trunc;
  assign comp_in = (comp_en && t_in != '0) ? (PW'(1) << (t_in - TW'(1))) : '0;

  // Ready ripples back from out_ready; each slot's source is the previous slot (or the input port).
  always_comb begin
    slot_load = '0;
    src_valid = '0;
    slot_load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      slot_load[k] = !valid_q[k] || slot_load[k+1];
    end
    src_valid[0] = in_valid;
    src_acc[0]   = comp_in;
    src_a[0]     = a;
    src_b[0]     = b;
    src_t[0]     = t_in;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_acc[k]   = acc_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_t[k]     = t_q[k-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      assign grp_sum[gi] = rows_sum(src_a[gi], src_b[gi], src_t[gi], gi * RPG, (gi + 1) * RPG);
      assign acc_d[gi]   = src_acc[gi] + grp_sum[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        t_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (slot_load[k]) begin
          valid_q[k] <= src_valid[k];
          // Data only moves with a real item so a stalled or empty slot keeps its contents.
          if (src_valid[k]) begin
            acc_q[k] <= acc_d[k];
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            t_q[k]   <= src_t[k];
          end
        end
      end
    end
  end

  assign in_ready  = slot_load[0] && !rst;
  assign out_valid = valid_q[STAGES-1];
  assign o         = acc_q[STAGES-1];

endmodule

// File: tb/tb_mul_approx_pipe.sv
// Scoreboard bench for mul_approx_pipe: driver pushes expected results, monitor pops on each output transfer.
module tb_mul_approx_pipe;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int TWB = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [TWB-1:0] trunc = '0;
  logic           comp_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] o;

  mul_approx_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .trunc(trunc), .comp_en(comp_en),
    .out_valid(out_valid), .out_ready(out_ready), .o(o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    logic [63:0] prod;
    int          t;
    int          acc_cyc;
    bit          lat;
  } item_t;

  item_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int accepted = 0;
  int mode = 0;          // 0: out_ready high, 1: out_ready low, 2: random
  bit mon_hold = 0;
  logic [2*W-1:0] mon_held = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mode == 0)      out_ready = 1'b1;
    else if (mode == 1) out_ready = 1'b0;
    else                out_ready = 1'($urandom_range(0, 1));
  end

  // Anything in flight at reset must never reach the output.
  always @(posedge rst) begin
    sb.delete();
    mon_hold = 0;
  end

  // Reference: exact product minus every dropped partial-product bit, plus the rounding constant.
  function automatic logic [63:0] model(int av, int bv, int tr, bit ce);
    int t;
    longint drop;
    longint r;
    t = (tr > W) ? W : tr;
    drop = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j < t && ((av >> i) & 1) == 1 && ((bv >> j) & 1) == 1)
          drop += longint'(1) << (i + j);
    r = longint'(av) * longint'(bv) - drop;
    if (ce && t > 0) r += longint'(1) << (t - 1);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(int av, int bv, int tr, bit ce, logic [63:0] exp, bit lat);
    item_t it;
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = av[W-1:0];
      b        = bv[W-1:0];
      trunc    = tr[TWB-1:0];
      comp_en  = ce;
      #1;
      if (in_ready) begin
        it.exp     = exp;
        it.prod    = longint'(av) * longint'(bv);
        it.t       = (tr > W) ? W : tr;
        it.acc_cyc = cyc;
        it.lat     = lat;
        @(posedge clk);
        sb.push_back(it);
        accepted++;
        done = 1;
        #1 in_valid = 1'b0;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !out_valid) ok = 1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d items pending expected 0", sb.size());
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when out_valid && out_ready here.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        mon_hold = 0;
      end else begin
        if (mon_hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(o), 64'(mon_held));
        end
        mon_hold = 0;
        if (out_valid) begin
          if (!out_ready) begin
            mon_hold = 1;
            mon_held = o;
          end else if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got o=%0d expected no output", o);
          end else begin
            it = sb.pop_front();
            check("result", 64'(o), it.exp);
            if (it.t == 0) check("exact_product", 64'(o), it.prod);
            if (it.lat) check("latency", 64'(cyc - it.acc_cyc), 64'(S));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int av, bv, tr;
    bit ce;

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_o", 64'(o), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    mode = 0;

    send(255, 255, 0, 0, 64'd65025, 1); drain();
    send(255, 255, 4, 0, 64'd64976, 1); drain();
    send(255, 255, 4, 1, 64'd64984, 1); drain();
    send(3, 5, 8, 0, 64'd0, 1);         drain();
    send(3, 5, 8, 1, 64'd128, 1);       drain();
    send(3, 5, 12, 1, 64'd128, 1);      drain();

    // Backpressure: 6 items while the sink stalls for 5 cycles.
    mode = 1;
    @(negedge clk);
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          av = int'($urandom_range(0, 2**W - 1));
          bv = int'($urandom_range(0, 2**W - 1));
          tr = int'($urandom_range(0, 2**TWB - 1));
          ce = 1'($urandom_range(0, 1));
          send(av, bv, tr, ce, model(av, bv, tr, ce), 0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        check("stall_accepts", 64'(accepted), 64'(S));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        mode = 0;
      end
    join
    drain();

    // Reset with two items in flight.
    mode = 1;
    @(negedge clk);
    send(200, 100, 2, 1, model(200, 100, 2, 1), 0);
    send(17, 250, 0, 0, model(17, 250, 0, 0), 0);
    @(negedge clk);
    #2;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_o", 64'(o), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("reset_hold_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    mode = 0;
    repeat (10) @(negedge clk);
    #3;
    check("post_reset_quiet", 64'(out_valid), 64'd0);

    // Random soak with random sink backpressure and input gaps.
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      av = int'($urandom_range(0, 2**W - 1));
      bv = int'($urandom_range(0, 2**W - 1));
      tr = int'($urandom_range(0, 2**TWB - 1));
      ce = 1'($urandom_range(0, 1));
      send(av, bv, tr, ce, model(av, bv, tr, ce), 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
